// File: rtl/sd_otf_converter_if.sv
// sd_otf_converter_if: digit-in / word-out handshake bundle for the on-the-fly converter
interface sd_otf_converter_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_first;
    logic [1:0]       in_digit;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_q;
    logic             err_sync;
    modport master (
        output in_valid, in_first, in_digit, out_ready,
        input  in_ready, out_valid, out_q, err_sync
    );
    modport slave (
        input  in_valid, in_first, in_digit, out_ready,
        output in_ready, out_valid, out_q, err_sync
    );
endinterface

// File: rtl/sd_otf_converter.sv
// sd_otf_converter: MSD-first radix-2 signed-digit stream to two's-complement word without a carry chain
module sd_otf_converter #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    sd_otf_converter_if.slave bus
);
    localparam int            CW   = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [CW-1:0]  cnt, cnt_n;
    logic [WIDTH:0] q, qm, q_n, qm_n, nq, nqm, out_q, out_q_n;
    logic [WIDTH-1:0] src_q, src_qm;
    logic out_valid, out_valid_n, err_sync, err_n;
    logic accept, drop, framed, last, d_pos, d_neg;
    assign bus.in_ready  = !(out_valid && !bus.out_ready && cnt == LAST);
    assign bus.out_valid = out_valid;
    assign bus.out_q     = out_q;
    assign bus.err_sync  = err_sync;
    // Q/QM append selection, framing checks and next-state for the collect counter and output slot
    always_comb begin
        accept      = bus.in_valid && bus.in_ready;
        d_pos       = bus.in_digit == 2'b10;
        d_neg       = bus.in_digit == 2'b01;
        src_q       = bus.in_first ? '0 : q[WIDTH-1:0];
        src_qm      = bus.in_first ? '1 : qm[WIDTH-1:0];
        nq          = d_neg ? {src_qm, 1'b1} : {src_q, d_pos};
        nqm         = d_pos ? {src_q, 1'b0} : {src_qm, !d_neg};
        drop        = accept && !bus.in_first && cnt == '0;
        framed      = accept && !drop;
        last        = framed && (bus.in_first ? WIDTH == 1 : cnt == LAST);
        err_n       = drop || (accept && bus.in_first && cnt != '0);
        cnt_n       = !framed ? cnt : last ? '0 : bus.in_first ? CW'(1) : cnt + CW'(1);
        q_n         = !framed ? q : last ? '0 : nq;
        qm_n        = !framed ? qm : last ? '1 : nqm;
        out_q_n     = last ? nq : out_q;
        out_valid_n = last || (out_valid && !bus.out_ready);
    end
    // State registers; reset restores Q=0, QM=-1 and an empty output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            q         <= '0;
            qm        <= '1;
            out_q     <= '0;
            out_valid <= 1'b0;
            err_sync  <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            q         <= q_n;
            qm        <= qm_n;
            out_q     <= out_q_n;
            out_valid <= out_valid_n;
            err_sync  <= err_n;
        end
    end
endmodule

// File: tb/tb_sd_otf_converter.sv
// tb_sd_otf_converter: directed WIDTH=4 vector table plus WIDTH=32 streams against an integer model
module tb_sd_otf_converter;
    localparam logic [1:0] P = 2'b10, N = 2'b01, Z = 2'b00, ZZ = 2'b11;
    typedef struct {
        logic       v, f;
        logic [1:0] d;
        logic       ordy, rdy, ov;
        logic [4:0] q;
        logic       err;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1;
    int checks = 0, errors = 0;
    vec_t vt[$];
    longint val;
    logic [32:0] e;
    logic [1:0] dg;
    always #5 clk = ~clk;
    sd_otf_converter_if #(.WIDTH(4))  b4();
    sd_otf_converter_if #(.WIDTH(32)) b32();
    sd_otf_converter #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave));
    sd_otf_converter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic apply4(input vec_t t, input string tag);
        b4.in_valid = t.v; b4.in_first = t.f; b4.in_digit = t.d; b4.out_ready = t.ordy;
        #1;
        chk({tag, " in_ready"}, b4.in_ready, t.rdy);
        @(posedge clk); #1;
        chk({tag, " out_valid"}, b4.out_valid, t.ov);
        chk({tag, " err_sync"}, b4.err_sync, t.err);
        if (t.ov) chk({tag, " out_q"}, b4.out_q, t.q);
    endtask
    initial begin
        b4.in_valid = 0; b4.in_first = 0; b4.in_digit = Z; b4.out_ready = 0;
        b32.in_valid = 0; b32.in_first = 0; b32.in_digit = Z; b32.out_ready = 1;
        vt.push_back('{1,1,P,1, 1,0,5'd0,0});
        vt.push_back('{1,0,Z,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,0,5'd0,0});
        vt.push_back('{1,0,P,1, 1,1,5'd7,0});
        vt.push_back('{0,0,Z,1, 1,0,5'd0,0});
        vt.push_back('{1,1,N,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,1,5'b10001,0});
        vt.push_back('{1,1,P,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,1,5'b00001,0});
        vt.push_back('{1,1,P,1, 1,0,5'd0,0});
        vt.push_back('{1,0,Z,0, 1,0,5'd0,0});
        vt.push_back('{1,0,Z,0, 1,0,5'd0,0});
        vt.push_back('{1,0,Z,0, 1,1,5'b01000,0});
        vt.push_back('{1,1,N,0, 1,1,5'b01000,0});
        vt.push_back('{1,0,Z,0, 1,1,5'b01000,0});
        vt.push_back('{1,0,Z,0, 1,1,5'b01000,0});
        vt.push_back('{1,0,P,0, 0,1,5'b01000,0});
        vt.push_back('{1,0,P,0, 0,1,5'b01000,0});
        vt.push_back('{1,0,P,1, 1,1,5'b11001,0});
        vt.push_back('{0,0,Z,1, 1,0,5'd0,0});
        vt.push_back('{1,1,P,1, 1,0,5'd0,0});
        vt.push_back('{1,0,P,1, 1,0,5'd0,0});
        vt.push_back('{1,1,N,1, 1,0,5'd0,1});
        vt.push_back('{1,0,Z,1, 1,0,5'd0,0});
        vt.push_back('{1,0,Z,1, 1,0,5'd0,0});
        vt.push_back('{1,0,Z,1, 1,1,5'b11000,0});
        vt.push_back('{1,0,P,1, 1,0,5'd0,1});
        vt.push_back('{0,0,Z,1, 1,0,5'd0,0});
        vt.push_back('{1,1,P,1, 1,0,5'd0,0});
        vt.push_back('{1,0,ZZ,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,0,5'd0,0});
        vt.push_back('{1,0,N,1, 1,1,5'b00101,0});
        vt.push_back('{0,0,Z,1, 1,0,5'd0,0});
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", b4.out_valid, 0);
        chk("reset out_q", b4.out_q, 0);
        chk("reset err_sync", b4.err_sync, 0);
        chk("reset in_ready", b4.in_ready, 1);
        chk("reset out_q w32", b32.out_q, 0);
        chk("reset out_valid w32", b32.out_valid, 0);
        rst = 0;
        foreach (vt[i]) apply4(vt[i], $sformatf("row%0d", i));
        apply4('{1,1,P,0, 1,0,5'd0,0}, "pre_rst0");
        apply4('{1,0,P,0, 1,0,5'd0,0}, "pre_rst1");
        apply4('{1,0,P,0, 1,0,5'd0,0}, "pre_rst2");
        apply4('{1,0,P,0, 1,1,5'd15,0}, "pre_rst3");
        apply4('{1,1,P,0, 1,1,5'd15,0}, "pre_rst4");
        apply4('{1,0,P,0, 1,1,5'd15,0}, "pre_rst5");
        b4.in_valid = 0; b4.out_ready = 0;
        rst = 1;
        #1;
        chk("async rst out_valid", b4.out_valid, 0);
        chk("async rst out_q", b4.out_q, 0);
        chk("async rst in_ready", b4.in_ready, 1);
        @(posedge clk); #1;
        rst = 0;
        apply4('{1,0,P,1, 1,0,5'd0,1}, "post_rst_drop");
        apply4('{1,1,P,1, 1,0,5'd0,0}, "post_rst0");
        apply4('{1,0,P,1, 1,0,5'd0,0}, "post_rst1");
        apply4('{1,0,P,1, 1,0,5'd0,0}, "post_rst2");
        apply4('{1,0,P,1, 1,1,5'd15,0}, "post_rst3");
        apply4('{0,0,Z,1, 1,0,5'd0,0}, "post_rst_idle");
        for (int w = 0; w < 20; w++) begin
            val = 0;
            for (int i = 0; i < 32; i++) begin
                dg = w == 0 ? P : w == 1 ? N : 2'($urandom_range(0, 3));
                val = val * 2 + (dg == P ? 1 : dg == N ? -1 : 0);
                b32.in_valid = 1; b32.in_first = i == 0; b32.in_digit = dg;
                #1;
                chk($sformatf("w32 word%0d digit%0d in_ready", w, i), b32.in_ready, 1);
                @(posedge clk); #1;
                chk($sformatf("w32 word%0d digit%0d out_valid", w, i), b32.out_valid, i == 31);
                chk($sformatf("w32 word%0d digit%0d err_sync", w, i), b32.err_sync, 0);
                if (i == 31) begin
                    e = val[32:0];
                    chk($sformatf("w32 word%0d out_q", w), b32.out_q, e);
                end
            end
        end
        b32.in_valid = 0;
        @(posedge clk); #1;
        chk("w32 drain out_valid", b32.out_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
